// File: rtl/fntt_pkg.sv
// Shared types and helpers for the sequential forward NTT.
// Holds the controller state encoding and the bit-reversal index map.
package fntt_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } fntt_state_e;

  function automatic int unsigned bitrev(
    input int unsigned v,
    input int unsigned logn
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (i < int'(logn))
        r = {r[30:0], v[i]};
    return r;
  endfunction

endpackage

// File: rtl/fntt_if.sv
// Coefficient load and result drain streams of fntt_seq.
// master drives the source/sink side, slave is the transform core.
interface fntt_if
  import fntt_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fntt_bfly.sv
// Radix-2 Cooley-Tukey butterfly over Z/mod, purely combinational.
// Operands must already be reduced below mod.
module fntt_bfly
  import fntt_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  input  logic [W-1:0] mod,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   v;
  logic [W:0]     s_raw;
  logic [W:0]     d_raw;

  always_comb begin
    prod  = (2*W)'(b) * (2*W)'(w);
    v     = W'(prod % (2*W)'(mod));
    s_raw = {1'b0, a} + {1'b0, v};
    // adding mod first keeps the difference non-negative
    d_raw = {1'b0, a} - {1'b0, v} + {1'b0, mod};
    sum   = W'(s_raw % {1'b0, mod});
    diff  = W'(d_raw % {1'b0, mod});
  end

endmodule

// File: rtl/fntt_seq.sv
// Sequential forward NTT: bit-reversed load, one shared butterfly
// per cycle across all stages, natural-order drain.
module fntt_seq
  import fntt_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int LOGN = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        mod,
  input  logic [N-1:0][W-1:0] omegas,
  fntt_if.slave               io,
  output logic                busy,
  output logic                done
);

  fntt_state_e state, state_nx;

  logic [W-1:0]        mem [N];
  logic [W-1:0]        mod_q;
  logic [N-1:0][W-1:0] om_q;

  logic [LOGN-1:0] ld_cnt, rd_cnt;
  logic [LOGN-1:0] s_q, j_q, t_q;

  logic [LOGN:0]   half, span;
  logic [LOGN-1:0] k_lo, k_hi;
  logic [LOGN-1:0] tw_sh, tw_idx;
  logic            t_last, j_last, s_last;
  logic            bf_last, ld_last, rd_last;
  logic            in_fire, out_fire;
  logic [W-1:0]    bf_sum, bf_diff;

  assign in_fire  = io.in_valid & io.in_ready;
  assign out_fire = io.out_valid & io.out_ready;
  assign ld_last  = ld_cnt == LOGN'(N - 1);
  assign rd_last  = rd_cnt == LOGN'(N - 1);

  // butterfly addressing for stage s_q, group j_q, offset t_q
  always_comb begin
    half    = (LOGN+1)'(1) << s_q;
    span    = half << 1;
    k_lo    = j_q + t_q;
    k_hi    = k_lo + half[LOGN-1:0];
    tw_sh   = LOGN'(LOGN - 1) - s_q;
    tw_idx  = t_q << tw_sh;
    t_last  = {1'b0, t_q} == half - 1'b1;
    j_last  = {1'b0, j_q} + span == (LOGN+1)'(N);
    s_last  = s_q == LOGN'(LOGN - 1);
    bf_last = t_last & j_last & s_last;
  end

  fntt_bfly #(.W(W)) u_bfly (
    .a    (mem[k_lo]),
    .b    (mem[k_hi]),
    .w    (om_q[tw_idx]),
    .mod  (mod_q),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (in_fire && ld_last) state_nx = COMPUTE;
      COMPUTE: if (bf_last) state_nx = DRAIN;
      DRAIN:   if (out_fire && rd_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      LOAD:    io.in_ready = 1'b1;
      COMPUTE: ;
      DRAIN: begin
        io.out_valid = 1'b1;
        io.out_data  = mem[rd_cnt];
        done         = io.out_ready & rd_last;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q  <= '0;
      om_q   <= '0;
      ld_cnt <= '0;
      rd_cnt <= '0;
      s_q    <= '0;
      j_q    <= '0;
      t_q    <= '0;
      for (int i = 0; i < N; i++)
        mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          mod_q  <= mod;
          om_q   <= omegas;
          ld_cnt <= '0;
        end
        LOAD: if (in_fire) begin
          mem[LOGN'(bitrev(32'(ld_cnt), LOGN))] <= io.in_data;
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_last) begin
            s_q <= '0;
            j_q <= '0;
            t_q <= '0;
          end
        end
        COMPUTE: begin
          mem[k_lo] <= bf_sum;
          mem[k_hi] <= bf_diff;
          if (t_last) begin
            t_q <= '0;
            if (j_last) begin
              j_q <= '0;
              s_q <= s_q + 1'b1;
            end else begin
              j_q <= j_q + span[LOGN-1:0];
            end
          end else begin
            t_q <= t_q + 1'b1;
          end
          if (bf_last) rd_cnt <= '0;
        end
        DRAIN: if (out_fire) rd_cnt <= rd_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fntt_seq.sv
// Randomized scoreboard bench for fntt_seq against a direct DFT
// sum over Z/17, with stalls, stray starts and mid-run reset.
module tb_fntt_seq;

  localparam int N = 8;
  localparam int W = 8;
  localparam int P = 17;

  typedef int vec_t [N];

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [W-1:0]        mod = '0;
  logic [N-1:0][W-1:0] omegas = '0;
  logic                busy;
  logic                done;

  fntt_if #(.W(W)) io ();

  fntt_seq #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mod    (mod),
    .omegas (omegas),
    .io     (io),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int q [$];
  int cyc = 0;
  int beat_idx = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_ov = -1;
  int stall_at = -1;
  int stall_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: drives out_ready, pops the scoreboard on every accepted beat
  initial begin : mon
    bit           hold;
    logic [W-1:0] held;
    int           e;
    hold = 1'b0;
    held = '0;
    io.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (io.out_valid && beat_idx == stall_at && stall_left > 0) begin
        io.out_ready = 1'b0;
        stall_left--;
      end else begin
        io.out_ready = 1'b1;
      end
      #1;
      if (hold && io.out_valid)
        chk("hold", int'(io.out_data), int'(held));
      if (io.out_valid && first_ov < 0)
        first_ov = cyc;
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got %0d expected none", io.out_data);
        end else begin
          e = q.pop_front();
          chk($sformatf("out[%0d]", beat_idx), int'(io.out_data), e);
        end
        chk("done_last", int'(done), int'(beat_idx == N - 1));
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        beat_idx = (beat_idx == N - 1) ? 0 : beat_idx + 1;
      end else if (done) begin
        chk("done_stray", int'(done), 0);
        done_cnt++;
      end
      hold = io.out_valid && !io.out_ready;
      held = io.out_data;
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(io.in_ready), 0);
    chk({tag, "_out_valid"}, int'(io.out_valid), 0);
    chk({tag, "_out_data"}, int'(io.out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // caller is at a negedge; returns at a negedge
  task automatic run(
    input vec_t x,
    input int   w,
    input bit   gaps,
    input int   stall_b,
    input bit   stray,
    input bit   mid_rst
  );
    vec_t om;
    vec_t y;
    int   c0, d0, idx, ccnt, guard;
    bit   computing, sd;
    om[0] = 1;
    for (int i = 1; i < N; i++)
      om[i] = (om[i-1] * w) % P;
    for (int i = 0; i < N; i++) begin
      y[i] = 0;
      for (int n = 0; n < N; n++)
        y[i] = (y[i] + x[n] * om[(i * n) % N]) % P;
      if (!mid_rst) q.push_back(y[i]);
    end
    stall_at   = stall_b;
    stall_left = 5;
    first_ov   = -1;
    d0         = done_cnt;
    start      = 1'b1;
    mod        = W'(P);
    for (int i = 0; i < N; i++)
      omegas[i] = W'(om[i]);
    io.in_valid = 1'b1;
    io.in_data  = 8'hAA;
    c0 = cyc;
    @(negedge clk);
    start  = 1'b0;
    mod    = W'($urandom);
    omegas = {$urandom, $urandom};
    idx    = 0;
    guard  = 0;
    while (idx < N && guard < 200) begin
      io.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      io.in_data  = W'(x[idx]);
      if (io.in_valid && io.in_ready) idx++;
      guard++;
      @(negedge clk);
    end
    chk("load_beats", idx, N);
    io.in_valid = 1'b0;
    ccnt  = 0;
    guard = 0;
    sd    = 1'b0;
    while (done_cnt == d0 && guard < 300) begin
      computing = busy && !io.in_ready && !io.out_valid;
      if (computing) ccnt++;
      if (mid_rst && ccnt == 5) begin
        rst_n       = 1'b0;
        start       = 1'b0;
        io.in_valid = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        q.delete();
        beat_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      start = stray && ((computing && ccnt == 3) || (io.out_valid && !sd));
      if (io.out_valid) sd = 1'b1;
      io.in_valid = stray && computing;
      io.in_data  = 8'h55;
      guard++;
      @(negedge clk);
    end
    start       = 1'b0;
    io.in_valid = 1'b0;
    chk("done_count", done_cnt - d0, 1);
    chk("compute_cycles", ccnt, (N / 2) * $clog2(N));
    chk("queue_empty", q.size(), 0);
    if (!gaps && stall_b < 0) begin
      chk("first_valid_cycle", first_ov - c0, 21);
      chk("done_cycle", done_cyc - c0, 28);
    end
  endtask

  initial begin : main
    vec_t x;
    int   roots [4];
    roots = '{2, 8, 9, 15};
    io.in_valid = 1'b0;
    io.in_data  = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) x[i] = (i == 0) ? 1 : 0;
    run(x, 2, 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) x[i] = 1;
    run(x, 2, 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) x[i] = (i == 1) ? 1 : 0;
    run(x, 2, 1'b0, -1, 1'b0, 1'b0);
    run(x, 2, 1'b1, 3, 1'b0, 1'b0);
    run(x, 2, 1'b0, -1, 1'b1, 1'b0);

    for (int i = 0; i < N; i++) x[i] = 1;
    run(x, 2, 1'b0, -1, 1'b0, 1'b1);
    run(x, 2, 1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) x[i] = $urandom_range(0, P - 1);
      run(x, roots[$urandom_range(0, 3)], r[0],
          (r % 3 == 0) ? $urandom_range(0, N - 1) : -1, r[1], 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fntt_seq.md
# fntt_seq

Sequential controller for the forward NTT. It accepts N coefficients over a valid/ready stream and stores them in bit-reversed order in an internal coefficient register file. It then steps a single shared radix-2 butterfly through all LOGN stages, one butterfly per cycle, and streams the natural-order result back out. It replaces the fully unrolled combinational transform wherever area matters more than latency.

## Interface
- N, 8, transform size; power of two, ≥ 2
- LOGN, $clog2(N), stage count
- W, 8, coefficient / modulus width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a transform; honoured only in IDLE
- mod  input  W  modulus; sampled on accepted start
- omegas  input  W × [N]  twiddle table, omegas[i] = ω^i mod `mod`; sampled on accepted start
- in_valid / in_ready  input / output  1  coefficient load handshake
- in_data  input  W  coefficient; must be < mod
- out_valid / out_ready  output / input  1  result handshake
- out_data  output  W  result coefficient, natural order
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse with the final accepted output beat

## Operation
- States: IDLE → LOAD → COMPUTE → DRAIN → IDLE.
- **IDLE**
  - start=1: latch mod and omegas, clear the load counter, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - in_ready=1.
  - Beat n (0..N-1) writes mem[bitrev_LOGN(n)] ← in_data.
  - After beat N-1 is accepted, go to COMPUTE with s=0, j=0, t=0.
- **COMPUTE**
  - Stage s: half = 2^s, M = 2^(s+1).
  - Each cycle performs one butterfly:
    - k = j + t, partner k+half
    - twiddle index g = t·(N/M)
    - U = mem[k], V = (mem[k+half]·omegas[g]) mod mod
    - mem[k] ← (U+V) mod mod
    - mem[k+half] ← (U−V+mod) mod mod
  - Loop order: t is innermost (0..half-1), then j (0, M, 2M, … < N), then s (0..LOGN-1).
  - After the last butterfly of stage LOGN-1, go to DRAIN with the read index at 0.
- **DRAIN**
  - out_valid=1, out_data=mem[r].
  - r advances only when out_ready=1.
  - When beat N-1 is accepted: done=1 for that cycle, go to IDLE.
- **Arithmetic**
  - Product is 2W bits and is reduced with %.
  - U+V and U−V+mod are computed at W+1 bits, then reduced.
  - Every stored value is < mod, provided all inputs are < mod.
- **Boundary behaviour**
  - start outside IDLE: ignored, no effect.
  - in_valid outside LOAD: ignored.
  - mod and omegas changing after an accepted start: no effect on the running transform.
  - Back-to-back start in the cycle after done: accepted.
- **Reset** (any time, including mid-LOAD or mid-COMPUTE):
  - state=IDLE, all counters 0, mem cleared to 0, latched mod/omegas cleared to 0.
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0.

## Timing
- Accepted start (cycle 0) puts LOAD in effect at cycle 1; in_ready rises at cycle 1.
- LOAD runs at full throughput: with in_valid held high, LOAD lasts N cycles.
- COMPUTE lasts exactly (N/2)·LOGN cycles: 12 for N=8. No stall sources.
- out_valid rises the cycle after the last butterfly.
  - N=8 with no stalls: first out_valid at cycle 21.
  - done on the last beat at cycle 28.
- All outputs are registered or decoded from the registered state: no combinational path from in_* or out_ready to the *_valid/*_ready outputs, except out_data following r.
- out_data is stable while out_valid=1 and out_ready=0.

## Structure
- Package fntt_pkg holds:
  - state enum fntt_state_e {IDLE, LOAD, COMPUTE, DRAIN}
  - a bitrev function parameterised on LOGN
  - the default N/W constants
- Sub-module fntt_bfly: purely combinational, inputs (a, b, w, mod), outputs (a', b').
  - Holds all modular arithmetic.
  - Is the shared resource that the unrolled transform reuses.

## Test plan
All scenarios use N=8, mod=17, omegas = 1,2,4,8,16,15,13,9 (ω=2).
- Impulse: input 1,0,0,0,0,0,0,0 → output all 1s; done pulses once.
- Constant: input all 1s → output 8,0,0,0,0,0,0,0.
- Shifted impulse: input 0,1,0,0,0,0,0,0 → output 1,2,4,8,16,15,13,9.
- Backpressure and cycle timing:
  - Random in_valid gaps and out_ready held low for 5 cycles mid-DRAIN.
  - Results match the shifted-impulse case.
  - out_data holds during stalls.
  - COMPUTE spans exactly 12 cycles.
- Stray start: pulse start during COMPUTE and DRAIN → no effect on results or cycle counts.
- Mid-compute reset:
  - Assert rst_n=0 at COMPUTE cycle 5 → all outputs are 0 and busy=0 immediately.
  - A following constant-input run yields 8,0,0,0,0,0,0,0.
